// File: rtl/sgen_fcw_sweep.sv
// FCW sweep (chirp) generator feeding sgen_nco's i_fcw.
// Modes: single up-ramp, repeating sawtooth, triangle; each FCW is held for dwell+1 enabled cycles.
module sgen_fcw_sweep #(
    parameter int unsigned gp_phase_accu_width = 16,
    parameter int unsigned gp_dwell_width      = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_ena,
    input  logic                           i_start,
    input  logic                           i_abort,
    input  logic [1:0]                     i_mode,
    input  logic [gp_phase_accu_width-1:0] i_fcw_start,
    input  logic [gp_phase_accu_width-1:0] i_fcw_stop,
    input  logic [gp_phase_accu_width-1:0] i_fcw_step,
    input  logic [gp_dwell_width-1:0]      i_dwell,
    output logic [gp_phase_accu_width-1:0] o_fcw,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_wrap
);
    localparam int unsigned W  = gp_phase_accu_width;
    localparam int unsigned DW = gp_dwell_width;
    localparam int unsigned WX = W + 1;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]    mode;
        logic          degen;
        logic [W-1:0]  fcw_start;
        logic [W-1:0]  fcw_stop;
        logic [W-1:0]  fcw_step;
        logic [DW-1:0] dwell;
    } cfg_t;

    state_t        state_q, state_d;
    cfg_t          cfg_q, cfg_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  fcw_q, fcw_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          wrap_q, wrap_d;

    logic [WX-1:0] up_sum;
    logic [WX-1:0] dn_diff;
    logic [W-1:0]  up_next;
    logic [W-1:0]  dn_next;

    // Clamped neighbours of the current FCW, computed one bit wider so nothing wraps
    always_comb begin
        up_sum  = {1'b0, fcw_q} + {1'b0, cfg_q.fcw_step};
        dn_diff = {1'b0, fcw_q} - {1'b0, cfg_q.fcw_step};
        up_next = (up_sum > {1'b0, cfg_q.fcw_stop}) ? cfg_q.fcw_stop : up_sum[W-1:0];
        dn_next = (dn_diff[W] || (dn_diff[W-1:0] < cfg_q.fcw_start)) ? cfg_q.fcw_start
                                                                        : dn_diff[W-1:0];
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        cnt_d   = cnt_q;
        fcw_d   = fcw_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        if (i_abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            fcw_d   = '0;
            busy_d  = 1'b0;
        end else if (i_ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        cfg_d.mode      = (i_mode == MODE_RSVD) ? MODE_SINGLE : i_mode;
                        cfg_d.degen     = (i_fcw_step == '0) || (i_fcw_start >= i_fcw_stop);
                        cfg_d.fcw_start = i_fcw_start;
                        cfg_d.fcw_stop  = i_fcw_stop;
                        cfg_d.fcw_step  = i_fcw_step;
                        cfg_d.dwell     = i_dwell;
                        state_d         = ST_UP;
                        cnt_d           = '0;
                        fcw_d           = i_fcw_start;
                        busy_d          = 1'b1;
                    end
                end
                default: begin
                    if (cnt_q != cfg_q.dwell) begin
                        cnt_d = cnt_q + DW'(1);
                    end else begin
                        cnt_d = '0;
                        if (state_q == ST_DOWN) begin
                            if (fcw_q == cfg_q.fcw_start) begin
                                state_d = ST_UP;
                                wrap_d  = 1'b1;
                                fcw_d   = up_next;
                            end else begin
                                fcw_d = dn_next;
                            end
                        end else if (cfg_q.degen || (fcw_q == cfg_q.fcw_stop)) begin
                            // End of ramp; a degenerate repeating sweep just parks at start
                            if (cfg_q.mode == MODE_SAW) begin
                                if (!cfg_q.degen) begin
                                    fcw_d  = cfg_q.fcw_start;
                                    wrap_d = 1'b1;
                                end
                            end else if (cfg_q.mode == MODE_TRI) begin
                                if (!cfg_q.degen) begin
                                    state_d = ST_DOWN;
                                    wrap_d  = 1'b1;
                                    fcw_d   = dn_next;
                                end
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end
                        end else begin
                            fcw_d = up_next;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cfg_q   <= '0;
            cnt_q   <= '0;
            fcw_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            cnt_q   <= cnt_d;
            fcw_q   <= fcw_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o_fcw  = fcw_q;
    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_wrap = wrap_q;

endmodule

// File: doc/sgen_fcw_sweep.md
Name: sgen_fcw_sweep

Overview:
- Frequency-control-word sweep (chirp) generator. Sits directly upstream of sgen_nco; o_fcw drives the NCO's i_fcw.
- Steps the FCW linearly from a start value to a stop value. Each value is held for a programmable dwell time.
- Three modes: single-shot up-sweep, repeating sawtooth, continuous triangle.
- Used for swept-sine stimulus and chirp generation in the sgen family.

Parameters:
- gp_phase_accu_width, 16, width of every FCW value; must equal the NCO's gp_phase_accu_width.
- gp_dwell_width, 16, width of the dwell counter and of i_dwell.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_ena  input  1  clock enable; low freezes state, counters and outputs.
- i_start  input  1  single-cycle start request.
- i_abort  input  1  single-cycle abort request.
- i_mode  input  2  sweep mode. 0 = single up, 1 = repeat sawtooth, 2 = triangle, 3 = reserved (behaves as 0).
- i_fcw_start  input  gp_phase_accu_width  unsigned start FCW.
- i_fcw_stop  input  gp_phase_accu_width  unsigned stop FCW.
- i_fcw_step  input  gp_phase_accu_width  unsigned increment per step.
- i_dwell  input  gp_dwell_width  each FCW value is held for i_dwell+1 enabled cycles.
- o_fcw  output  gp_phase_accu_width  current FCW to the NCO (registered).
- o_busy  output  1  high while a sweep is active.
- o_done  output  1  one-cycle pulse at completion of a single-shot sweep.
- o_wrap  output  1  one-cycle pulse when mode 1 restarts at start, or mode 2 reverses direction.

Behaviour:
- Reset (i_rst=1 at a clock edge, any state):
  - o_fcw=0, o_busy=0, o_done=0, o_wrap=0.
  - State IDLE, dwell counter 0. Overrides all other inputs.
- Configuration:
  - i_mode, i_fcw_start, i_fcw_stop, i_fcw_step and i_dwell are latched on an accepted start.
  - Later changes to these inputs have no effect until the next start.
- States: IDLE, UP, DOWN.
- Start acceptance:
  - Accepted only when IDLE, i_ena=1 and i_start=1. Ignored while busy.
  - Accepted start at edge N: from cycle N+1, o_fcw=start, o_busy=1, state UP, dwell counter 0. Latency is 1 cycle.
- Dwell:
  - The counter increments on each enabled cycle.
  - When it reaches the latched dwell value, it clears and a step event occurs.
  - So each o_fcw value is visible for exactly dwell+1 enabled cycles.
- UP step:
  - Compute nxt = cur + step at gp_phase_accu_width+1 bits. No wrap-around is allowed.
  - If cur == stop, this is an end-of-ramp event. Otherwise o_fcw = min(nxt, stop); the final step clamps to stop.
- End-of-ramp in UP:
  - Mode 0: state IDLE, o_busy=0, o_done=1 for one cycle. o_fcw holds stop until the next start, abort or reset.
  - Mode 1: o_fcw=start, o_wrap=1, remain UP.
  - Mode 2: state DOWN, o_wrap=1. Compute o_fcw = max(stop - step, start) at width+1 bits; no borrow wrap.
- DOWN step:
  - If cur == start: state UP, o_wrap=1, o_fcw = min(start + step, stop).
  - Otherwise o_fcw = max(cur - step, start).
- Degenerate configuration (step==0 or start>=stop):
  - o_fcw = start.
  - Mode 0: completes after one dwell; o_done as normal.
  - Modes 1 and 2: hold start indefinitely, o_busy=1, no o_wrap pulses.
- Abort:
  - i_abort=1 at any edge (independent of i_ena): next cycle state IDLE, o_busy=0, o_fcw=0, no o_done.
  - Abort and start in the same cycle: abort wins.
- i_ena=0: all registers hold, including o_fcw. o_done and o_wrap are forced low.
- Pulse outputs: o_done and o_wrap are registered and last exactly one cycle.

Test Plan:
- Reset and idle: assert i_rst mid-sweep (mode 1, o_fcw=40) -> next cycle o_fcw=0, o_busy=0. Later i_start pulses while i_rst=1 are ignored.
- Single up: start=10, stop=40, step=10, dwell=1, mode 0 -> o_fcw sequence 10,10,20,20,30,30,40,40. Then o_done for 1 cycle, o_busy falls on the same cycle, o_fcw stays 40.
- Clamp and sawtooth: start=0, stop=25, step=10, dwell=0, mode 1 -> 0,10,20,25,0,10,... with o_wrap on each cycle where o_fcw returns to 0.
- Triangle with overflow guard: width 16, start=0xFFF0, stop=0xFFFF, step=0x000C, dwell=0, mode 2 -> FFF0, FFFC, FFFF, FFF3, FFF0, FFFC, ... No wrap through 0. o_wrap when FFFF goes to FFF3 and when FFF0 goes to FFFC.
- Enable/abort: toggle i_ena low for 5 cycles mid-dwell -> o_fcw and the dwell count freeze, and the total visible cycles still equal dwell+1 enabled cycles. Then i_abort together with i_start -> o_fcw=0, o_busy=0, no o_done.
- Degenerate: step=0 in mode 2 -> o_fcw=start held forever, o_busy=1, no o_wrap. A start>=stop config in mode 0 -> one dwell at start, then o_done.
